// File: rtl/decrementer16bit_seq_pkg.sv
// Shared definitions for the sequential decrementer: default width and FSM state encoding.
package decrementer16bit_seq_pkg;

  localparam int WIDTH_DEFAULT = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage : decrementer16bit_seq_pkg

// File: rtl/decrementer16bit_seq_full_subtractor.sv
// One-bit full subtractor built from gate primitives: d = a - b - bin, bout = borrow out.
module full_subtractor
  import decrementer16bit_seq_pkg::*;
(
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  logic a_xor_b_s;
  logic a_n_s;
  logic a_xnor_b_s;
  logic borrow_gen_s;
  logic borrow_prop_s;

  xor g_x0 (a_xor_b_s, a, b);
  xor g_x1 (d, a_xor_b_s, bin);
  not g_n0 (a_n_s, a);
  and g_a0 (borrow_gen_s, a_n_s, b);
  not g_n1 (a_xnor_b_s, a_xor_b_s);
  and g_a1 (borrow_prop_s, a_xnor_b_s, bin);
  or  g_o0 (bout, borrow_gen_s, borrow_prop_s);

endmodule : full_subtractor

// File: rtl/decrementer16bit_seq.sv
// Loadable down-counter with IDLE/COUNT/DONE control; the decrement comes from a ripple borrow chain.
module decrementer16bit_seq
  import decrementer16bit_seq_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] din,
  input  logic             en,
  input  logic             abort,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             zero,
  output logic             done
);

  localparam logic [WIDTH-1:0] ALL_ZERO = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};

  state_t           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] dec_s;
  logic [WIDTH-1:0] borrow_s;
  logic             bout_unused_s;

  // Borrow chain computing count_q - 1; the top borrow only matters for count 0, which never decrements.
  assign borrow_s[0] = 1'b0;
  for (genvar i = 0; i < WIDTH; i++) begin : g_chain
    localparam logic SUB_BIT = (i == 0) ? 1'b1 : 1'b0;
    logic bout_s;
    full_subtractor u_fs (
      .a    (count_q[i]),
      .b    (SUB_BIT),
      .bin  (borrow_s[i]),
      .d    (dec_s[i]),
      .bout (bout_s)
    );
    if (i < WIDTH - 1) begin : g_link
      assign borrow_s[i+1] = bout_s;
    end else begin : g_last
      assign bout_unused_s = bout_s;
    end
  end

  // Next-state and next-count logic
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          count_d = din;
          state_d = (din != ALL_ZERO) ? COUNT : DONE;
        end else begin
          state_d = IDLE;
        end
      end
      COUNT: begin
        if (abort) begin
          state_d = IDLE;
        end else if (en) begin
          count_d = dec_s;
          state_d = (count_q == ONE) ? DONE : COUNT;
        end else begin
          state_d = COUNT;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and count registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      count_q <= ALL_ZERO;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  assign count = count_q;
  assign busy  = (state_q == COUNT);
  assign done  = (state_q == DONE);
  assign zero  = (count_q == ALL_ZERO);

endmodule : decrementer16bit_seq

// File: tb/tb_decrementer16bit_seq.sv
// Scoreboard bench for decrementer16bit_seq: each drive pushes the expected post-edge outputs.
module tb_decrementer16bit_seq;

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] din;
  logic        en;
  logic        abort;
  logic [15:0] count;
  logic        busy;
  logic        zero;
  logic        done;

  typedef struct packed {
    logic [15:0] count;
    logic        busy;
    logic        done;
    logic        zero;
  } out_t;

  out_t exp_q[$];
  out_t obs_q[$];
  int   errors = 0;
  int   checks = 0;

  decrementer16bit_seq #(.WIDTH(16)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .din   (din),
    .en    (en),
    .abort (abort),
    .count (count),
    .busy  (busy),
    .zero  (zero),
    .done  (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Apply one cycle of inputs, record what should appear after the edge and what actually does.
  task automatic drive(input logic r, input logic s, input logic [15:0] d, input logic e,
                       input logic a, input logic [15:0] ec, input logic eb, input logic ed,
                       input logic ez);
    out_t x;
    rst = r; start = s; din = d; en = e; abort = a;
    x.count = ec; x.busy = eb; x.done = ed; x.zero = ez;
    exp_q.push_back(x);
    @(posedge clk);
    @(negedge clk);
    x.count = count; x.busy = busy; x.done = done; x.zero = zero;
    obs_q.push_back(x);
  endtask

  task automatic test_reset();
    out_t e, o;
    int   n = 0;
    drive(1'b1, 1'b1, 16'h0007, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);
    drive(1'b1, 1'b1, 16'h0007, 1'b1, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b1);
    drive(1'b0, 1'b1, 16'h0003, 1'b0, 1'b0, 16'h0003, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h0003, 1'b0, 1'b0, 1'b0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++; n++;
      if (o !== e) begin
        errors++;
        $display("FAIL reset step %0d: got count=%h busy=%b done=%b zero=%b, expected count=%h busy=%b done=%b zero=%b",
                 n, o.count, o.busy, o.done, o.zero, e.count, e.busy, e.done, e.zero);
      end
    end
  endtask

  task automatic test_basic();
    out_t e, o;
    int   n = 0;
    drive(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);
    drive(1'b0, 1'b1, 16'h0003, 1'b1, 1'b0, 16'h0003, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0002, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0001, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b1);
    drive(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++; n++;
      if (o !== e) begin
        errors++;
        $display("FAIL basic step %0d: got count=%h busy=%b done=%b zero=%b, expected count=%h busy=%b done=%b zero=%b",
                 n, o.count, o.busy, o.done, o.zero, e.count, e.busy, e.done, e.zero);
      end
    end
  endtask

  task automatic test_zero_load();
    out_t e, o;
    int   n = 0;
    drive(1'b0, 1'b1, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b1);
    drive(1'b0, 1'b1, 16'h0004, 1'b1, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b1);
    drive(1'b0, 1'b0, 16'h0004, 1'b1, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b1);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++; n++;
      if (o !== e) begin
        errors++;
        $display("FAIL zero_load step %0d: got count=%h busy=%b done=%b zero=%b, expected count=%h busy=%b done=%b zero=%b",
                 n, o.count, o.busy, o.done, o.zero, e.count, e.busy, e.done, e.zero);
      end
    end
  endtask

  task automatic test_enable_gaps();
    out_t        e, o;
    int          n = 0;
    logic [15:0] cur;
    logic        en_bit;
    drive(1'b0, 1'b1, 16'h0005, 1'b0, 1'b0, 16'h0005, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++)
      drive(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0005, 1'b1, 1'b0, 1'b0);
    cur = 16'h0005;
    for (int i = 0; i < 9; i++) begin
      en_bit = (i % 2 == 0);
      if (en_bit) cur = cur - 16'h0001;
      drive(1'b0, 1'b0, 16'h0000, en_bit, 1'b0, cur, cur != 16'h0000, cur == 16'h0000, cur == 16'h0000);
    end
    drive(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++; n++;
      if (o !== e) begin
        errors++;
        $display("FAIL enable_gaps step %0d: got count=%h busy=%b done=%b zero=%b, expected count=%h busy=%b done=%b zero=%b",
                 n, o.count, o.busy, o.done, o.zero, e.count, e.busy, e.done, e.zero);
      end
    end
  endtask

  // Counting down from 0xFFFF exercises one decrement from every value 0xFFFF..1.
  task automatic test_full_range();
    out_t        e, o;
    int          n = 0;
    logic [15:0] nxt;
    drive(1'b0, 1'b1, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0, 1'b0);
    for (int v = 65535; v >= 1; v--) begin
      nxt = 16'(v - 1);
      drive(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, nxt, v != 1, v == 1, v == 1);
    end
    drive(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++; n++;
      if (o !== e) begin
        errors++;
        $display("FAIL full_range step %0d: got count=%h busy=%b done=%b zero=%b, expected count=%h busy=%b done=%b zero=%b",
                 n, o.count, o.busy, o.done, o.zero, e.count, e.busy, e.done, e.zero);
      end
    end
  endtask

  task automatic test_abort();
    out_t e, o;
    int   n = 0;
    drive(1'b0, 1'b1, 16'h0010, 1'b1, 1'b0, 16'h0010, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h000F, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h000E, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h000D, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h000C, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 16'h000C, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h000C, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 16'h0002, 1'b1, 1'b0, 16'h0002, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0001, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b1);
    drive(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++; n++;
      if (o !== e) begin
        errors++;
        $display("FAIL abort step %0d: got count=%h busy=%b done=%b zero=%b, expected count=%h busy=%b done=%b zero=%b",
                 n, o.count, o.busy, o.done, o.zero, e.count, e.busy, e.done, e.zero);
      end
    end
  endtask

  task automatic test_ignored_start();
    out_t e, o;
    int   n = 0;
    drive(1'b0, 1'b1, 16'h0006, 1'b1, 1'b0, 16'h0006, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0005, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0004, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 16'h0009, 1'b1, 1'b0, 16'h0003, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 16'h0009, 1'b1, 1'b0, 16'h0002, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0001, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b1);
    drive(1'b0, 1'b1, 16'h0009, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++; n++;
      if (o !== e) begin
        errors++;
        $display("FAIL ignored_start step %0d: got count=%h busy=%b done=%b zero=%b, expected count=%h busy=%b done=%b zero=%b",
                 n, o.count, o.busy, o.done, o.zero, e.count, e.busy, e.done, e.zero);
      end
    end
  endtask

  task automatic test_midrun_reset();
    out_t e, o;
    int   n = 0;
    drive(1'b0, 1'b1, 16'h0005, 1'b1, 1'b0, 16'h0005, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0004, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0003, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0002, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);
    drive(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++; n++;
      if (o !== e) begin
        errors++;
        $display("FAIL midrun_reset step %0d: got count=%h busy=%b done=%b zero=%b, expected count=%h busy=%b done=%b zero=%b",
                 n, o.count, o.busy, o.done, o.zero, e.count, e.busy, e.done, e.zero);
      end
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; din = 16'h0000; en = 1'b0; abort = 1'b0;
    test_reset();
    test_basic();
    test_zero_load();
    test_enable_gaps();
    test_abort();
    test_ignored_start();
    test_midrun_reset();
    test_full_range();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_decrementer16bit_seq
